// File: rtl/bk_pkg.sv
// Shared definitions for the BK interrupt controller: register offsets, FSM states
// and the byte-lane write mask helper.
package bk_pkg;

    localparam logic [4:0] IRQ_MASK   = 5'o00;
    localparam logic [4:0] IRQ_PEND   = 5'o02;
    localparam logic [4:0] IRQ_SWTRIG = 5'o04;
    localparam logic [4:0] IRQ_STATUS = 5'o06;
    localparam logic [4:0] IRQ_LEVEL  = 5'o10;
    localparam logic [4:0] IRQ_VEC0   = 5'o20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } irq_state_t;

    // Bits of a 16-bit register touched by a word or single-lane byte write.
    function automatic logic [15:0] lane_mask(input logic byte_en, input logic hi);
        if (!byte_en) return 16'hFFFF;
        return hi ? 16'hFF00 : 16'h00FF;
    endfunction

endpackage

// File: rtl/bk_prio_enc.sv
// Lowest-index-wins priority encoder over up to 8 request lines.
module bk_prio_enc #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] req,
    output logic           valid,
    output logic [2:0]     idx
);

    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/bk_irq_ctrl.sv
// BK vectored interrupt controller: NCH edge-triggered channels with MASK/PEND/SWTRIG/STATUS/VEC
// registers. Define IRQ_LEVEL_EN to add the per-channel LEVEL register at offset 010.
//
// state | meaning
// IDLE  | no request presented; iako_i here is a spurious acknowledge
// REQ   | virq_o raised while an enabled channel is pending; grant tracks live
// ACK   | acknowledge in progress; vector_o frozen until iako_i drops
module bk_irq_ctrl
    import bk_pkg::*;
#(
    parameter int          NCH      = 4,
    parameter logic [15:0] VEC_BASE = 16'o000300,
    parameter logic [15:0] SPUR_VEC = 16'o000000
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ce,
    input  logic [NCH-1:0] irq_i,
    input  logic           sel_i,
    input  logic [4:0]     addr_i,
    input  logic           wt_i,
    input  logic           rd_i,
    input  logic           byte_i,
    input  logic [15:0]    data_i,
    output logic [15:0]    data_o,
    output logic           reply_o,
    output logic           bad_o,
    output logic           virq_o,
    input  logic           iako_i,
    output logic [15:0]    vector_o,
    output logic [2:0]     active_o
);

    logic [NCH-1:0] mask, pend, pend_next, samp, level, set, clr, ack_clr;
    logic           gen, req, enc_valid, load_vec, access, we;
    logic [15:0]    vec [NCH];
    logic [15:0]    lane, wbits, rd_val, vec_val;
    logic [4:0]     off;
    logic [2:0]     enc_idx, grant, grant_next;
    logic           is_mask, is_pend, is_swtrig, is_status, is_level, is_vec, mapped;
    irq_state_t     state, state_next;

    assign access    = sel_i & (rd_i | wt_i);
    assign we        = sel_i & wt_i;
    assign off       = {addr_i[4:1], 1'b0};
    assign lane      = lane_mask(byte_i, addr_i[0]);
    assign wbits     = data_i & lane;
    assign is_mask   = (off == IRQ_MASK);
    assign is_pend   = (off == IRQ_PEND);
    assign is_swtrig = (off == IRQ_SWTRIG);
    assign is_status = (off == IRQ_STATUS);
    assign is_vec    = ((off & IRQ_VEC0) == IRQ_VEC0) && ({1'b0, addr_i[3:1]} < 4'(NCH));
    assign mapped    = is_mask | is_pend | is_swtrig | is_status | is_level | is_vec;

`ifdef IRQ_LEVEL_EN
    assign is_level = (off == IRQ_LEVEL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            level <= '0;
        else if (ce && we && is_level)
            level <= (level & ~lane[NCH-1:0]) | wbits[NCH-1:0];
    end
`else
    assign is_level = 1'b0;
    assign level    = '0;
`endif

    bk_prio_enc #(.NCH(NCH)) u_prio (
        .req   (pend & mask),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    assign req      = gen & enc_valid;
    assign virq_o   = (state == REQ) & req;
    assign active_o = (state == ACK) ? grant : enc_idx;

    always_comb begin
        rd_val = '0;
        if (is_mask)   rd_val = {gen, 15'(mask)};
        if (is_pend)   rd_val = 16'(pend);
        if (is_status) rd_val = {virq_o, state == ACK, 11'b0, active_o};
        if (is_level)  rd_val = 16'(level);
        for (int i = 0; i < NCH; i++)
            if (is_vec && addr_i[3:1] == 3'(i)) rd_val = vec[i];
    end

    // Setting sources are ORed in after clearing so a simultaneous set wins.
    always_comb begin
        set       = irq_i & (~samp | level);
        set       = set | ((we && is_swtrig) ? wbits[NCH-1:0] : '0);
        clr       = ack_clr | ((we && is_pend) ? wbits[NCH-1:0] : '0);
        pend_next = (pend & ~clr) | set;
    end

    always_comb begin
        state_next = state;
        ack_clr    = '0;
        load_vec   = 1'b0;
        vec_val    = SPUR_VEC;
        grant_next = 3'd0;
        case (state)
            IDLE: begin
                if (iako_i) begin
                    state_next = ACK;
                    load_vec   = 1'b1;
                end else if (req) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (iako_i) begin
                    state_next = ACK;
                    load_vec   = 1'b1;
                    grant_next = enc_idx;
                    for (int i = 0; i < NCH; i++) begin
                        if (enc_idx == 3'(i)) begin
                            vec_val    = vec[i];
                            ack_clr[i] = 1'b1;
                        end
                    end
                end
            end
            ACK: begin
                if (!iako_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= 3'd0;
            vector_o <= SPUR_VEC;
        end else if (ce) begin
            state <= state_next;
            if (load_vec) begin
                vector_o <= vec_val;
                grant    <= grant_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask   <= '0;
            gen    <= 1'b0;
            pend   <= '0;
            samp   <= '0;
            data_o <= '0;
            bad_o  <= 1'b0;
            for (int i = 0; i < NCH; i++) vec[i] <= VEC_BASE + 16'(4 * i);
        end else if (ce) begin
            samp  <= irq_i;
            pend  <= pend_next;
            bad_o <= access & ~mapped;
            if (access && !mapped)  data_o <= 16'o177777;
            else if (sel_i && rd_i) data_o <= rd_val;
            else                    data_o <= '0;
            if (we && is_mask) begin
                mask <= (mask & ~lane[NCH-1:0]) | wbits[NCH-1:0];
                if (lane[15]) gen <= wbits[15];
            end
            for (int i = 0; i < NCH; i++)
                if (we && is_vec && addr_i[3:1] == 3'(i))
                    vec[i] <= {(vec[i][15:2] & ~lane[15:2]) | wbits[15:2], 2'b00};
        end
    end

    // Reply sets on any clock edge, independent of ce, and clears on the next ce.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            reply_o <= 1'b0;
        else if (access && !reply_o)
            reply_o <= 1'b1;
        else if (ce)
            reply_o <= 1'b0;
    end

endmodule
